// File: rtl/button_pkg.sv
// Shared types and elaboration-time helpers for the push-button bank.
package button_pkg;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'b00,
        EDGE_FALL = 2'b01,
        EDGE_BOTH = 2'b10,
        EDGE_OFF  = 2'b11
    } edge_mode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRESS  = 2'd1,
        REPEAT = 2'd2
    } hold_state_t;

    // 64-bit math so long hold times at fast clocks do not overflow.
    function automatic longint unsigned ms_to_cycles(input longint unsigned ms,
                                                     input longint unsigned period_ns,
                                                     input longint unsigned min_cycles);
        longint unsigned cycles;
        cycles = (ms * 64'd1_000_000) / period_ns;
        return (cycles < min_cycles) ? min_cycles : cycles;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button: 2-flop synchronizer, debouncer, edge gate and long-press/auto-repeat FSM.
module button_channel
    import button_pkg::*;
#(
    parameter int CLK_PERIOD_NS    = 5,
    parameter int DEBOUNCE_TIME_MS = 5,
    parameter int HOLD_TIME_MS     = 500,
    parameter int REPEAT_TIME_MS   = 100,
    parameter int ACTIVE_LOW       = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       raw,
    input  logic [1:0] edge_mode,
    input  logic       repeat_en,
    output logic       level,
    output logic       clean_signal,
    output logic       held
);

    localparam int unsigned DB_CYCLES  =
        32'(ms_to_cycles(64'(DEBOUNCE_TIME_MS), 64'(CLK_PERIOD_NS), 64'd1));
    localparam int unsigned HOLD_CYCLES =
        32'(ms_to_cycles(64'(HOLD_TIME_MS), 64'(CLK_PERIOD_NS), 64'd2));
    localparam int unsigned REP_CYCLES =
        32'(ms_to_cycles(64'(REPEAT_TIME_MS), 64'(CLK_PERIOD_NS), 64'd1));

    localparam int DB_W   = $clog2(DB_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int REP_W  = $clog2(REP_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REP_CYCLES - 1);
    localparam logic              IDLE_RAW  = (ACTIVE_LOW != 0);

    logic [1:0]        sync_q;
    logic              synced;
    logic [DB_W-1:0]   db_cnt_q;
    logic              level_q, level_prev_q;
    logic              mismatch, flip, rise_now, fall_now;
    logic              changed, edge_hit, rep_ok, rep_fire;
    logic              clean_q;
    edge_mode_t        mode;
    hold_state_t       state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;

    // Synchronizer idles at the inactive raw value so reset release never looks like a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= {2{IDLE_RAW}};
        else     sync_q <= {sync_q[0], raw};
    end

    assign synced   = sync_q[1] ^ IDLE_RAW;
    assign mismatch = synced != level_q;
    assign flip     = mismatch && (db_cnt_q == DB_LAST);
    assign rise_now = flip & ~level_q;
    assign fall_now = flip & level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt_q     <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
        end else begin
            level_prev_q <= level_q;
            if (!mismatch) begin
                db_cnt_q <= '0;
            end else if (flip) begin
                db_cnt_q <= '0;
                level_q  <= ~level_q;
            end else begin
                db_cnt_q <= db_cnt_q + 1'b1;
            end
        end
    end

    assign mode    = edge_mode_t'(edge_mode);
    assign changed = level_q ^ level_prev_q;
    assign rep_ok  = repeat_en && (mode == EDGE_RISE || mode == EDGE_BOTH);

    always_comb begin
        edge_hit = 1'b0;
        case (mode)
            EDGE_RISE: edge_hit = changed & level_q;
            EDGE_FALL: edge_hit = changed & ~level_q;
            EDGE_BOTH: edge_hit = changed;
            default:   edge_hit = 1'b0;
        endcase
    end

    // FSM follows the debouncer's flip strobes so held drops on the same edge as level.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        rep_fire   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise_now) begin
                    state_d    = PRESS;
                    hold_cnt_d = '0;
                end
            end
            PRESS: begin
                if (fall_now) begin
                    state_d    = IDLE;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = REPEAT;
                    hold_cnt_d = '0;
                    rep_cnt_d  = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            REPEAT: begin
                if (fall_now) begin
                    state_d   = IDLE;
                    rep_cnt_d = '0;
                end else begin
                    rep_fire  = (rep_cnt_q == '0);
                    rep_cnt_d = (rep_cnt_q == REP_LAST) ? '0 : rep_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                hold_cnt_d = '0;
                rep_cnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            rep_cnt_q  <= '0;
            clean_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
            clean_q    <= edge_hit | (rep_fire & rep_ok);
        end
    end

    assign level        = level_q;
    assign clean_signal = clean_q;
    assign held         = (state_q == REPEAT);

endmodule

// File: rtl/button_bank.sv
// Bank of independent debounced button channels with a combined event strobe.
module button_bank
    import button_pkg::*;
#(
    parameter int NUM_BUTTONS      = 4,
    parameter int CLK_PERIOD_NS    = 5,
    parameter int DEBOUNCE_TIME_MS = 5,
    parameter int HOLD_TIME_MS     = 500,
    parameter int REPEAT_TIME_MS   = 100,
    parameter int ACTIVE_LOW       = 0
) (
    input  logic                     clk,
    input  logic                     sys_rst,
    input  logic [NUM_BUTTONS-1:0]   signal,
    input  logic [2*NUM_BUTTONS-1:0] edge_mode,
    input  logic [NUM_BUTTONS-1:0]   repeat_en,
    output logic [NUM_BUTTONS-1:0]   level,
    output logic [NUM_BUTTONS-1:0]   clean_signal,
    output logic [NUM_BUTTONS-1:0]   held,
    output logic                     any_event
);

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
        button_channel #(
            .CLK_PERIOD_NS   (CLK_PERIOD_NS),
            .DEBOUNCE_TIME_MS(DEBOUNCE_TIME_MS),
            .HOLD_TIME_MS    (HOLD_TIME_MS),
            .REPEAT_TIME_MS  (REPEAT_TIME_MS),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_ch (
            .clk         (clk),
            .rst         (sys_rst),
            .raw         (signal[i]),
            .edge_mode   (edge_mode[2*i +: 2]),
            .repeat_en   (repeat_en[i]),
            .level       (level[i]),
            .clean_signal(clean_signal[i]),
            .held        (held[i])
        );
    end

    assign any_event = |clean_signal;

endmodule

// File: tb/tb_button_bank.sv
// Self-checking bench for button_bank: press-profile table, timed corner sequences, random vs model.
module tb_button_bank;

    localparam int NB = 4, DB = 4, HOLD = 20, REP = 5;

    logic          clk, sys_rst;
    logic [NB-1:0] raw, raw_al, ren;
    logic [7:0]    mode;
    logic [NB-1:0] level, clean_signal, held, al_level, al_clean, al_held;
    logic          any_event, al_any;

    button_bank #(.NUM_BUTTONS(NB), .CLK_PERIOD_NS(1_000_000), .DEBOUNCE_TIME_MS(4),
                  .HOLD_TIME_MS(20), .REPEAT_TIME_MS(5), .ACTIVE_LOW(0)) dut (
        .clk(clk), .sys_rst(sys_rst), .signal(raw), .edge_mode(mode), .repeat_en(ren),
        .level(level), .clean_signal(clean_signal), .held(held), .any_event(any_event));

    button_bank #(.NUM_BUTTONS(NB), .CLK_PERIOD_NS(1_000_000), .DEBOUNCE_TIME_MS(4),
                  .HOLD_TIME_MS(20), .REPEAT_TIME_MS(5), .ACTIVE_LOW(1)) dut_al (
        .clk(clk), .sys_rst(sys_rst), .signal(raw_al), .edge_mode(mode), .repeat_en(ren),
        .level(al_level), .clean_signal(al_clean), .held(al_held), .any_event(al_any));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0, bad = 0, n_edge = 0;

    // Reference model: a press is accepted once DB consecutive synced samples disagree with level.
    int m_smp[NB][DB+1];
    int m_level[NB], m_rise[NB], m_fprev[NB];
    logic [NB-1:0] e_level, e_clean, e_held;
    int acc_pulse[NB], acc_held[NB], acc_level[NB], acc_any;

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s @edge%0d got=%0h want=%0h", nm, n_edge, got, want);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NB; c++) begin
            m_level[c] = 0; m_rise[c] = 0; m_fprev[c] = 0;
            for (int k = 0; k <= DB; k++) m_smp[c][k] = 0;
        end
        e_level = '0; e_clean = '0; e_held = '0;
    endtask

    task automatic model_edge();
        n_edge++;
        if (sys_rst) begin
            model_reset();
            return;
        end
        for (int c = 0; c < NB; c++) begin
            int  md, newl, k;
            bit  mis, p;
            md  = int'(mode[2*c +: 2]);
            mis = 1'b1;
            for (int j = 1; j <= DB; j++) if (m_smp[c][j] == m_level[c]) mis = 1'b0;
            newl = mis ? 1 - m_level[c] : m_level[c];
            p = 1'b0;
            if (m_fprev[c] == 1 && (md == 0 || md == 2)) p = 1'b1;
            if (m_fprev[c] == 2 && (md == 1 || md == 2)) p = 1'b1;
            if (mis && newl == 1) m_rise[c] = n_edge;
            if (m_level[c] == 1 && newl == 1) begin
                k = n_edge - m_rise[c];
                if (k >= HOLD + 1 && (k - HOLD - 1) % REP == 0 && ren[c] && (md == 0 || md == 2))
                    p = 1'b1;
            end
            e_held[c]  = (newl == 1) && (n_edge - m_rise[c] >= HOLD);
            e_level[c] = (newl == 1);
            e_clean[c] = p;
            m_fprev[c] = mis ? ((newl == 1) ? 1 : 2) : 0;
            m_level[c] = newl;
            for (int j = DB; j >= 1; j--) m_smp[c][j] = m_smp[c][j-1];
            m_smp[c][0] = int'(raw[c]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("level", int'(level), int'(e_level));
        chk("clean_signal", int'(clean_signal), int'(e_clean));
        chk("held", int'(held), int'(e_held));
        chk("any_event", int'(any_event), int'(|e_clean));
        for (int c = 0; c < NB; c++) begin
            acc_pulse[c] += int'(clean_signal[c]);
            acc_held[c]  += int'(held[c]);
            acc_level[c] += int'(level[c]);
        end
        acc_any += int'(any_event);
    endtask

    task automatic clear_acc();
        for (int c = 0; c < NB; c++) begin
            acc_pulse[c] = 0; acc_held[c] = 0; acc_level[c] = 0;
        end
        acc_any = 0;
    endtask

    typedef struct {
        int ch; int md; int re; int dur; int pulses; int held_cyc;
    } vec_t;
    vec_t vecs[11];

    initial begin
        int lvl_first, clean_at, clean_cnt, held_first, al_full, al_cycles, al_at;

        // {channel, mode, repeat_en, press cycles, expected pulses, expected held cycles}
        vecs[0]  = '{0, 0, 0, 10, 1, 0};
        vecs[1]  = '{1, 2, 0, 10, 2, 0};
        vecs[2]  = '{1, 1, 0, 10, 1, 0};
        vecs[3]  = '{1, 3, 0, 10, 0, 0};
        vecs[4]  = '{2, 0, 1, 50, 7, 30};
        vecs[5]  = '{2, 0, 0, 50, 1, 30};
        vecs[6]  = '{3, 2, 1, 30, 4, 10};
        vecs[7]  = '{3, 1, 1, 30, 1, 10};
        vecs[8]  = '{0, 0, 1, 20, 1, 0};
        vecs[9]  = '{0, 0, 1, 21, 1, 1};
        vecs[10] = '{0, 0, 1, 22, 2, 2};

        sys_rst = 1'b1; raw = '0; raw_al = '1; mode = '0; ren = '0;
        model_reset();
        clear_acc();
        repeat (3) tick();
        chk("al_reset_level", int'(al_level), 0);
        chk("al_reset_clean", int'(al_clean), 0);
        sys_rst = 1'b0;
        repeat (5) tick();

        // Clean press on ch0: level at edge 6, single pulse at edge 7, no pulse on release.
        raw[0] = 1'b1; lvl_first = 0; clean_at = 0; clean_cnt = 0;
        for (int e = 1; e <= 14; e++) begin
            tick();
            if (level[0] && lvl_first == 0) lvl_first = e;
            if (clean_signal[0]) begin clean_cnt++; clean_at = e; end
        end
        chk("press_level_edge", lvl_first, 6);
        chk("press_pulse_edge", clean_at, 7);
        chk("press_pulse_cnt", clean_cnt, 1);
        raw[0] = 1'b0; clean_cnt = 0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (clean_signal[0]) clean_cnt++;
        end
        chk("release_no_pulse", clean_cnt, 0);
        chk("release_level", int'(level[0]), 0);

        // Bounce: 2-cycle toggles for 12 cycles then steady high.
        lvl_first = 0; clean_at = 0; clean_cnt = 0;
        for (int e = 1; e <= 30; e++) begin
            raw[0] = (e > 12) ? 1'b1 : ((((e - 1) / 2) % 2) == 0);
            tick();
            if (level[0] && lvl_first == 0) lvl_first = e;
            if (clean_signal[0]) begin clean_cnt++; clean_at = e; end
        end
        chk("bounce_level_edge", lvl_first, 18);
        chk("bounce_pulse_edge", clean_at, 19);
        chk("bounce_pulse_cnt", clean_cnt, 1);
        raw[0] = 1'b0;
        repeat (20) tick();

        // Press-duration table across modes and repeat settings.
        for (int v = 0; v < 11; v++) begin
            mode[2*vecs[v].ch +: 2] = 2'(vecs[v].md);
            ren[vecs[v].ch] = (vecs[v].re != 0);
            clear_acc();
            raw[vecs[v].ch] = 1'b1;
            repeat (vecs[v].dur) tick();
            raw[vecs[v].ch] = 1'b0;
            repeat (40) tick();
            chk($sformatf("vec%0d_pulses", v), acc_pulse[vecs[v].ch], vecs[v].pulses);
            chk($sformatf("vec%0d_held", v), acc_held[vecs[v].ch], vecs[v].held_cyc);
            chk($sformatf("vec%0d_level", v), acc_level[vecs[v].ch], vecs[v].dur);
            chk($sformatf("vec%0d_any", v), acc_any, vecs[v].pulses);
        end

        // Reset while ch2 is auto-repeating, button still held through reset.
        mode = '0; ren = 4'b0100; raw[2] = 1'b1;
        repeat (35) tick();
        chk("pre_reset_held", int'(held[2]), 1);
        #2 sys_rst = 1'b1;
        #1;
        chk("async_rst_level", int'(level), 0);
        chk("async_rst_clean", int'(clean_signal), 0);
        chk("async_rst_held", int'(held), 0);
        chk("async_rst_any", int'(any_event), 0);
        model_reset();
        repeat (3) tick();
        sys_rst = 1'b0;
        clean_at = 0; held_first = 0;
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (clean_signal[2] && clean_at == 0) clean_at = e;
            if (held[2] && held_first == 0) held_first = e;
        end
        chk("post_rst_pulse_edge", clean_at, 7);
        chk("post_rst_held_edge", held_first, 26);
        raw[2] = 1'b0; ren = '0;
        repeat (40) tick();

        // Active-low bank: all four pressed together.
        raw_al = '0; al_full = 0; al_cycles = 0; al_at = 0;
        for (int e = 1; e <= 15; e++) begin
            tick();
            if (al_clean != '0) begin
                al_cycles++; al_at = e;
                if (al_clean == 4'hF && al_any) al_full++;
            end
        end
        chk("al_full_pulse", al_full, 1);
        chk("al_pulse_cycles", al_cycles, 1);
        chk("al_pulse_edge", al_at, 7);
        chk("al_level", int'(al_level), 15);
        chk("al_held", int'(al_held), 0);
        raw_al = '1;
        repeat (20) tick();

        // Random stimulus against the model, including a mid-run asynchronous reset.
        for (int i = 0; i < 2500; i++) begin
            for (int c = 0; c < NB; c++) begin
                if ($urandom_range(0, 29) == 0) raw[c] = ~raw[c];
                if ($urandom_range(0, 79) == 0) mode[2*c +: 2] = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 99) == 0) ren[c] = 1'($urandom_range(0, 1));
            end
            if (i == 1200) begin
                sys_rst = 1'b1;
                model_reset();
            end
            if (i == 1203) sys_rst = 1'b0;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
